// File: rtl/seven_segment_pkg.sv
// Shared definitions for the seven-segment display driver and its loop-back decoder.
// Segment encodings are active-low, bit 0 = segment a ... bit 6 = segment g.
package seven_segment_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    WAIT,
    ACCEPT,
    HOLD
  } state_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational decode of one active-low segment pattern into a BCD value.
// Blank and illegal patterns both report value 4'hF.
module seg_pattern_decode
  import seven_segment_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] value,
  output logic       is_digit,
  output logic       is_blank
);

  always_comb begin
    value    = 4'hF;
    is_digit = 1'b1;
    is_blank = 1'b0;
    case (pattern)
      SEG_0:     value = 4'd0;
      SEG_1:     value = 4'd1;
      SEG_2:     value = 4'd2;
      SEG_3:     value = 4'd3;
      SEG_4:     value = 4'd4;
      SEG_5:     value = 4'd5;
      SEG_6:     value = 4'd6;
      SEG_7:     value = 4'd7;
      SEG_8:     value = 4'd8;
      SEG_9:     value = 4'd9;
      SEG_BLANK: begin
        is_digit = 1'b0;
        is_blank = 1'b1;
      end
      default:   is_digit = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_segment_decoder.sv
// Loop-back monitor for a multiplexed seven-segment bus: waits for each
// pin pattern to settle, then decodes it into per-digit BCD values.
module seven_segment_decoder
  import seven_segment_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   an,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_valid,
  output logic                    decode_error
);

  localparam int W  = NUM_DIGITS + 7;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [W-1:0]  s1, s2, prev, prev_n;
  logic [CW-1:0] cnt, cnt_n;
  state_t        state, state_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1    <= '1;
      s2    <= '1;
      prev  <= '1;
      cnt   <= '0;
      state <= WAIT;
    end else begin
      s1    <= {an, seg};
      s2    <= s1;
      prev  <= prev_n;
      cnt   <= cnt_n;
      state <= state_n;
    end
  end

  // Any change restarts settling; a settled pattern is accepted once, then held.
  always_comb begin
    prev_n  = prev;
    cnt_n   = cnt;
    state_n = state;
    if (s2 != prev) begin
      prev_n  = s2;
      cnt_n   = '0;
      state_n = WAIT;
    end else begin
      case (state)
        WAIT: begin
          if (cnt == CW'(STABLE_CYCLES - 1)) state_n = ACCEPT;
          else                               cnt_n   = cnt + 1'b1;
        end
        ACCEPT:  state_n = HOLD;
        HOLD:    state_n = HOLD;
        default: state_n = WAIT;
      endcase
    end
  end

  logic [NUM_DIGITS-1:0] prev_an;
  logic [3:0]            value;
  logic                  is_digit, is_blank;
  logic                  an_off, single_low;
  logic [IW-1:0]         low_idx;

  assign prev_an    = prev[W-1:7];
  assign an_off     = &prev_an;
  assign single_low = $onehot(~prev_an);

  seg_pattern_decode u_decode (
    .pattern  (prev[6:0]),
    .value    (value),
    .is_digit (is_digit),
    .is_blank (is_blank)
  );

  always_comb begin
    low_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!prev_an[i]) low_idx = IW'(i);
    end
  end

  logic [4*NUM_DIGITS-1:0] digits_n;
  logic [NUM_DIGITS-1:0]   valid_n, seen, seen_n, seen_tmp;
  logic                    frame_n, error_n;

  // Seen mask is cleared in the same cycle the frame pulse fires.
  always_comb begin
    digits_n = digits;
    valid_n  = digit_valid;
    seen_n   = seen;
    seen_tmp = seen;
    frame_n  = 1'b0;
    error_n  = 1'b0;
    if (state == ACCEPT) begin
      if (single_low) begin
        valid_n[low_idx] = is_digit;
        if (is_digit || is_blank) begin
          digits_n[{low_idx, 2'b00} +: 4] = value;
          seen_tmp[low_idx] = 1'b1;
          if (&seen_tmp) begin
            frame_n = 1'b1;
            seen_n  = '0;
          end else begin
            seen_n  = seen_tmp;
          end
        end else begin
          error_n = 1'b1;
        end
      end else if (!an_off) begin
        error_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits       <= '1;
      digit_valid  <= '0;
      seen         <= '0;
      frame_valid  <= 1'b0;
      decode_error <= 1'b0;
    end else begin
      digits       <= digits_n;
      digit_valid  <= valid_n;
      seen         <= seen_n;
      frame_valid  <= frame_n;
      decode_error <= error_n;
    end
  end

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Self-checking bench: directed scenarios plus random pin traffic, compared
// every cycle against a pin-history reference model of the decoder.
module tb_seven_segment_decoder;

  localparam int N = 8;
  localparam int S = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [6:0]     seg;
  logic [N-1:0]   an;
  logic [4*N-1:0] digits;
  logic [N-1:0]   digit_valid;
  logic           frame_valid, decode_error;

  int checks = 0;
  int fails  = 0;
  int frame_cnt = 0;
  int err_cnt   = 0;
  bit check_en  = 1'b0;

  seven_segment_decoder #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk          (clk),
    .reset        (reset),
    .seg          (seg),
    .an           (an),
    .digits       (digits),
    .digit_valid  (digit_valid),
    .frame_valid  (frame_valid),
    .decode_error (decode_error)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_table [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a pattern seen on S+1 consecutive clock samples is
  // accepted, and its effect shows up three edges after the last sample.
  logic [3:0]   m_digits [N];
  bit           m_valid  [N];
  bit           m_seen   [N];
  bit           m_frame, m_err;
  logic [N+6:0] pipe_pat [3];
  bit           pipe_v   [3];
  logic [N+6:0] last_sample;
  int           run;

  task automatic modelReset();
    for (int i = 0; i < N; i++) begin
      m_digits[i] = 4'hF;
      m_valid[i]  = 1'b0;
      m_seen[i]   = 1'b0;
    end
    m_frame = 1'b0;
    m_err   = 1'b0;
    for (int k = 0; k < 3; k++) pipe_v[k] = 1'b0;
    last_sample = '1;
    run = S + 2;
  endtask

  task automatic modelAccept(input logic [N+6:0] pat);
    logic [N-1:0] a;
    logic [6:0]   sv;
    int zeros, idx, found;
    bit all_seen;
    a = pat[N+6:7];
    sv = pat[6:0];
    zeros = 0;
    idx = 0;
    found = -1;
    for (int i = 0; i < N; i++) if (a[i] == 1'b0) begin zeros++; idx = i; end
    if (zeros > 1) m_err = 1'b1;
    else if (zeros == 1) begin
      for (int v = 0; v < 10; v++) if (seg_table[v] == sv) found = v;
      if (found >= 0 || sv == 7'h7F) begin
        m_digits[idx] = (found >= 0) ? 4'(found) : 4'hF;
        m_valid[idx]  = (found >= 0);
        m_seen[idx]   = 1'b1;
        all_seen = 1'b1;
        for (int i = 0; i < N; i++) if (!m_seen[i]) all_seen = 1'b0;
        if (all_seen) begin
          m_frame = 1'b1;
          for (int i = 0; i < N; i++) m_seen[i] = 1'b0;
        end
      end else begin
        m_valid[idx] = 1'b0;
        m_err = 1'b1;
      end
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) modelReset();
    else begin
      m_frame = 1'b0;
      m_err   = 1'b0;
      if (pipe_v[2]) modelAccept(pipe_pat[2]);
      pipe_v[2] = pipe_v[1]; pipe_pat[2] = pipe_pat[1];
      pipe_v[1] = pipe_v[0]; pipe_pat[1] = pipe_pat[0];
      pipe_v[0] = 1'b0;
      if ({an, seg} === last_sample) run++;
      else begin
        last_sample = {an, seg};
        run = 1;
      end
      if (run == S + 1) begin
        pipe_v[0]   = 1'b1;
        pipe_pat[0] = {an, seg};
      end
    end
  end

  always @(negedge clk) begin
    logic [4*N-1:0] exp_digits;
    logic [N-1:0]   exp_valid;
    if (check_en && !reset) begin
      for (int i = 0; i < N; i++) begin
        exp_digits[4*i +: 4] = m_digits[i];
        exp_valid[i] = m_valid[i];
      end
      checkOutput("digits", 64'(digits), 64'(exp_digits));
      checkOutput("digit_valid", 64'(digit_valid), 64'(exp_valid));
      checkOutput("frame_valid", 64'(frame_valid), 64'(m_frame));
      checkOutput("decode_error", 64'(decode_error), 64'(m_err));
      if (frame_valid) frame_cnt++;
      if (decode_error) err_cnt++;
    end
  end

  task automatic applyStimulus(input logic [N-1:0] a, input logic [6:0] s, input int cycles);
    an  = a;
    seg = s;
    repeat (cycles) @(negedge clk);
  endtask

  // Asserts reset between clock edges and checks the cleared outputs immediately.
  task automatic resetPulse();
    an  = '1;
    seg = '1;
    #2 reset = 1'b1;
    #1;
    checkOutput("reset_digits", 64'(digits), 64'hFFFF_FFFF);
    checkOutput("reset_valid", 64'(digit_valid), 64'h0);
    checkOutput("reset_frame", 64'(frame_valid), 64'h0);
    checkOutput("reset_error", 64'(decode_error), 64'h0);
    #1 reset = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [N-1:0] oneLow(input int i);
    logic [N-1:0] m;
    m = '1;
    m[i] = 1'b0;
    return m;
  endfunction

  initial begin
    int f0, e0, a, b, r;
    logic [N-1:0] an_v;
    logic [6:0]   seg_v;
    reset = 1'b0;
    an    = '1;
    seg   = '1;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_en = 1'b1;

    applyStimulus(oneLow(0), 7'b0100100, 12);
    checkOutput("single_digit", 64'(digits[3:0]), 64'd2);
    checkOutput("single_valid", 64'(digit_valid[0]), 64'd1);

    applyStimulus(oneLow(2), seg_table[5], 10);
    applyStimulus(oneLow(2), 7'b0000000, 3);
    checkOutput("glitch_hold", 64'(digits[11:8]), 64'd5);
    applyStimulus(oneLow(2), seg_table[5], 10);
    checkOutput("glitch_after", 64'(digits[11:8]), 64'd5);

    #1 f0 = frame_cnt;
    for (int i = 0; i < N; i++) applyStimulus(oneLow(i), seg_table[i], 8);
    applyStimulus('1, '1, 4);
    #1;
    checkOutput("frame_pulses", 64'(frame_cnt - f0), 64'd1);
    checkOutput("frame_digits", 64'(digits), 64'h7654_3210);
    checkOutput("frame_valid_all", 64'(digit_valid), 64'hFF);

    e0 = err_cnt;
    f0 = frame_cnt;
    applyStimulus(oneLow(3), 7'b0101010, 10);
    applyStimulus(8'b1111_1100, seg_table[1], 10);
    #1;
    checkOutput("error_pulses", 64'(err_cnt - e0), 64'd2);
    checkOutput("error_no_frame", 64'(frame_cnt - f0), 64'd0);
    checkOutput("error_digits", 64'(digits), 64'h7654_3210);
    checkOutput("error_valid", 64'(digit_valid), 64'hF7);

    for (int i = 0; i < 4; i++) applyStimulus(oneLow(i), seg_table[i], 8);
    resetPulse();
    #1 f0 = frame_cnt;
    for (int i = 0; i < N - 1; i++) applyStimulus(oneLow(i), seg_table[i], 8);
    #1;
    checkOutput("midframe_no_early", 64'(frame_cnt - f0), 64'd0);
    applyStimulus(oneLow(N - 1), seg_table[N - 1], 8);
    applyStimulus('1, '1, 2);
    #1;
    checkOutput("midframe_pulse", 64'(frame_cnt - f0), 64'd1);

    for (int t = 0; t < 300; t++) begin
      r = $urandom_range(0, 9);
      a = $urandom_range(0, N - 1);
      b = (a + $urandom_range(1, N - 1)) % N;
      if (r == 0)      an_v = '1;
      else if (r == 1) an_v = oneLow(a) & oneLow(b);
      else             an_v = oneLow(a);
      r = $urandom_range(0, 9);
      if (r < 7)       seg_v = seg_table[$urandom_range(0, 9)];
      else if (r == 7) seg_v = 7'h7F;
      else             seg_v = 7'($urandom);
      applyStimulus(an_v, seg_v, $urandom_range(1, 9));
      if (t == 150) resetPulse();
    end
    applyStimulus('1, '1, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/seven_segment_decoder.md
# seven_segment_decoder

Receive-side counterpart of the seven-segment display driver. It samples the active-low segment and anode lines of a multiplexed seven-segment display bus, waits for each pattern to settle, and decodes it back into per-digit BCD values with validity flags. It also flags patterns that are not legal digits and pulses once each time every digit position has been refreshed. It sits on the display pins as a loop-back monitor for self-check and bench use.

## Interface
- `NUM_DIGITS`, default 8: number of anode lines and digit positions.
- `STABLE_CYCLES`, default 4: consecutive identical synchronized samples required beyond the first before a pattern is accepted. Legal range is 1..255.
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: reset is asynchronous and active-high.
- `seg` input, 7 bits: segment lines, active-low, bit 0 = segment a … bit 6 = segment g.
- `an` input, `NUM_DIGITS` bits: anode enables, active-low, bit i = digit i.
- `digits` output, `4*NUM_DIGITS` bits: last accepted value of digit i, located at `[4i+3:4i]`.
- `digit_valid` output, `NUM_DIGITS` bits: bit i is high when digit i last decoded as a legal 0..9.
- `frame_valid` output, 1 bit: one-cycle pulse when all digit positions have been accepted since the last pulse.
- `decode_error` output, 1 bit: one-cycle pulse on acceptance of an illegal `seg` pattern or an illegal `an` pattern.

## Operation
- **Input synchronization:** `{an, seg}` passes through a 2-flop synchronizer. The second stage, `s2`, feeds all logic.
- **FSM states:** `WAIT`, `ACCEPT`, `HOLD`.
  - A register `prev` holds the last `s2` sample.
  - In any state, if `s2 != prev`: `prev <= s2`, `cnt <= 0`, state goes to `WAIT`.
  - In `WAIT` with `s2 == prev`:
    - If `cnt == STABLE_CYCLES-1`, go to `ACCEPT`.
    - Otherwise, `cnt <= cnt+1`.
  - `ACCEPT` lasts exactly one cycle and performs the update below. It then goes to `HOLD`.
  - In `HOLD`, stay while `s2 == prev`. A held pattern is accepted exactly once.
- **Acceptance rules, by `an` value:**
  - **All ones:** display off. No update, no error, no frame credit.
  - **Exactly one bit i low:** decode `seg`:
    - Legal digit 0..9: `digits[i] <= value`, `digit_valid[i] <= 1`, set `seen[i]`. Patterns are 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
    - Blank (1111111): `digits[i] <= 4'hF`, `digit_valid[i] <= 0`, set `seen[i]`.
    - Any other pattern: `digits[i]` unchanged, `digit_valid[i] <= 0`, `decode_error` pulse, `seen[i]` not set.
  - **More than one bit low:** `decode_error` pulse, no update, no frame credit.
- **Frame tracking:**
  - `seen` is a `NUM_DIGITS`-bit mask.
  - When an accept would make `seen` all ones, pulse `frame_valid` and clear `seen` to 0 in the same cycle.
  - Re-accepting an already-seen digit leaves `seen` as is.
- **Reset (asynchronous, any time):**
  - Synchronizer and `prev` go to all ones.
  - `cnt` = 0, state = `WAIT`, `seen` = 0.
  - `digits` = all `4'hF`, `digit_valid` = 0, `frame_valid` = 0, `decode_error` = 0.
  - A partial frame is discarded.

## Timing
- A pin change sampled at rising edge E0 reaches `s2` at E1. It is loaded into `prev` at E2. Outputs update at edge E(STABLE_CYCLES+3), provided the pattern is held throughout. With the default this is E7.
- Any change before acceptance restarts the count. A pattern held for fewer than `STABLE_CYCLES+1` synchronized cycles is never accepted.
- `frame_valid` and `decode_error` are registered. They assert in the same cycle the `digits` and `digit_valid` update is visible, and are mutually exclusive.
- At most one accept occurs per cycle.
- `cnt` width is `$clog2(STABLE_CYCLES+1)`. `cnt` never exceeds `STABLE_CYCLES-1`.

## Structure
- Shared package `seven_segment_pkg`:
  - Constants `SEG_0`…`SEG_9` and `SEG_BLANK`.
  - FSM state enum (`WAIT`/`ACCEPT`/`HOLD`).
  - These are shared with the display driver.
- Sub-module `seg_pattern_decode`: combinational, 7-bit pattern in; 4-bit `value`, `is_digit`, `is_blank` out. It is instantiated once.

## Test plan
- **Reset:** assert `reset` mid-run → `digits`=32'hFFFFFFFF, `digit_valid`=0, no pulses, checked before any clock edge.
- **Single digit:** `an`=8'b11111110, `seg`=0100100 held for 12 cycles → `digits[3:0]`=2 and `digit_valid[0]`=1 at edge 7. Exactly one accept occurs, with no further activity while held.
- **Glitch rejection:** stable digit 5 on `an[2]`, then `seg`=0000000 for 3 cycles, then back → `digits[11:8]` stays 5 throughout.
- **Full frame:** scan `an[i]` with digit i for i=0..7, each held 8 cycles → one `frame_valid` pulse coincident with the digit-7 update, `digits`=32'h76543210, `digit_valid`=8'hFF.
- **Errors:**
  - `seg`=0101010 on `an[3]` → `decode_error` pulse, `digit_valid[3]`=0, `digits[15:12]` unchanged, no `frame_valid`.
  - `an`=8'b11111100 → `decode_error` pulse, no update.
- **Reset mid-frame:** accept digits 0..3, pulse `reset`, then accept digits 0..7 → no `frame_valid` until digit 7 of the second pass.
